// File: rtl/spram_load_sequencer_pkg.sv
// spram_load_sequencer_pkg: shared state encoding, word-count clamp and default limits for the SPRAM load sequencer
package spram_load_sequencer_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_DROP,
    S_LOAD,
    S_PRIME,
    S_STREAM,
    S_DRAIN,
    S_HOLD,
    S_ERR
  } state_t;
  localparam logic [14:0] MAX_WORDS_DEF    = 15'd16384;
  localparam logic [23:0] LOAD_TIMEOUT_DEF = 24'd2_000_000;
  localparam logic [2:0]  DROP_CYCLES_DEF  = 3'd4;
  function automatic logic [14:0] clamp_words(input logic [14:0] n, input logic [14:0] lim);
    return (n > lim) ? lim : n;
  endfunction
endpackage

// File: rtl/spram_stream_outreg.sv
// spram_stream_outreg: 1-entry valid/ready output register that generates the FIFO pop enable
// Ports: clk/resetn; clr drops valid; en/avail qualify a pop; din is the FIFO head;
// ready from the consumer; pop to the FIFO; data/valid drive the stream.
module spram_stream_outreg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         clr,
  input  logic         en,
  input  logic         avail,
  input  logic         ready,
  input  logic [W-1:0] din,
  output logic         pop,
  output logic [W-1:0] data,
  output logic         valid
);
  // Pop only when the slot is empty or being drained this cycle, so data never changes under a stall.
  assign pop = en && avail && !clr && (!valid || ready);
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (pop) begin
      data  <= din;
      valid <= 1'b1;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/spram_load_sequencer.sv
// spram_load_sequencer: sequences loader init/fill, supervises load timeout and streams FIFO words downstream
// Ports: clk/resetn; i_start/i_skip_load/i_num_words/i_abort control; o_busy/o_done/o_error status;
// o_init/o_fill/i_load_done/i_fifo_empty/o_fifo_rd/i_fifo_dout loader side;
// o_data/o_valid/i_ready stream; o_words_left remaining words to pop.
module spram_load_sequencer
  import spram_load_sequencer_pkg::*;
#(
  parameter logic [23:0] LOAD_TIMEOUT = LOAD_TIMEOUT_DEF,
  parameter logic [14:0] MAX_WORDS    = MAX_WORDS_DEF,
  parameter logic [2:0]  DROP_CYCLES  = DROP_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_start,
  input  logic        i_skip_load,
  input  logic [14:0] i_num_words,
  input  logic        i_abort,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error,
  output logic        o_init,
  output logic        o_fill,
  input  logic        i_load_done,
  input  logic        i_fifo_empty,
  output logic        o_fifo_rd,
  input  logic [31:0] i_fifo_dout,
  output logic [31:0] o_data,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [14:0] o_words_left
);
  state_t      state, state_nx;
  logic [2:0]  drop_cnt;
  logic [23:0] tmo;
  logic        start_ok;
  logic        pop;
  assign start_ok = i_start && !i_abort && (state == S_IDLE || state == S_HOLD || state == S_ERR);
  assign o_fifo_rd = pop;
  // The last word is accepted when the slot drains with nothing left to pop, in STREAM or DRAIN.
  assign o_done = (state == S_STREAM || state == S_DRAIN) && o_words_left == 15'd0
                  && o_valid && i_ready && !i_abort;
  always_comb begin
    state_nx = state;
    o_init   = 1'b0;
    o_fill   = 1'b0;
    o_busy   = 1'b0;
    o_error  = 1'b0;
    if (i_abort) state_nx = S_IDLE;
    else case (state)
      S_IDLE:   if (i_start) state_nx = S_DROP;
      S_DROP:   if (drop_cnt == DROP_CYCLES - 3'd1) state_nx = S_LOAD;
      S_LOAD:   state_nx = i_load_done ? S_PRIME : (tmo == LOAD_TIMEOUT - 24'd1) ? S_ERR : S_LOAD;
      S_PRIME:  state_nx = (o_words_left == 15'd0) ? S_HOLD : !i_fifo_empty ? S_STREAM : S_PRIME;
      S_STREAM: if (o_words_left == 15'd0) state_nx = S_DRAIN;
      S_DRAIN:  if (!o_valid || i_ready) state_nx = S_HOLD;
      S_HOLD:   if (i_start) state_nx = i_skip_load ? S_PRIME : S_DROP;
      S_ERR:    if (i_start) state_nx = S_DROP;
      default:  state_nx = S_IDLE;
    endcase
    o_init  = state inside {S_LOAD, S_PRIME, S_STREAM, S_DRAIN, S_HOLD};
    o_fill  = state inside {S_PRIME, S_STREAM, S_DRAIN};
    o_busy  = state inside {S_DROP, S_LOAD, S_PRIME, S_STREAM, S_DRAIN};
    o_error = state == S_ERR;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= S_IDLE;
      drop_cnt     <= 3'd0;
      tmo          <= 24'd0;
      o_words_left <= 15'd0;
    end else begin
      state        <= state_nx;
      drop_cnt     <= (state == S_DROP) ? drop_cnt + 3'd1 : 3'd0;
      tmo          <= (state != S_LOAD) ? 24'd0 : (&tmo) ? tmo : tmo + 24'd1;
      o_words_left <= i_abort ? 15'd0 :
                      start_ok ? clamp_words(i_num_words, MAX_WORDS) :
                      pop ? o_words_left - 15'd1 : o_words_left;
    end
  end
  spram_stream_outreg #(.W(32)) u_outreg (
    .clk    (clk),
    .resetn (resetn),
    .clr    (i_abort),
    .en     (state == S_STREAM),
    .avail  (!i_fifo_empty && o_words_left != 15'd0),
    .ready  (i_ready),
    .din    (i_fifo_dout),
    .pop    (pop),
    .data   (o_data),
    .valid  (o_valid)
  );
endmodule

// File: doc/spram_load_sequencer.md
Name: spram_load_sequencer

Overview:
- Controller for the SPI-flash-to-SPRAM loader.
- Sequences the loader's init and fill controls, and supervises the load with a timeout.
- Pops a programmed number of 32-bit words from the loader FIFO and presents them on a valid/ready stream to the downstream consumer (e.g. weight/instruction fetch).
- Supports replaying a resident image without re-reading flash.

Parameters:
- LOAD_TIMEOUT, 24'd2_000_000: cycles allowed between entering LOAD and i_load_done; expiry leads to ERR.
- MAX_WORDS, 15'd16384: clamp for the requested word count (SPRAM bank depth).
- DROP_CYCLES, 3'd4: cycles o_init is held low before a new load; must be ≥2.

Ports:
- clk  in  1  system clock (= RISC-V clock)
- resetn  in  1  asynchronous active-low reset
- i_start  in  1  single-cycle request; accepted in IDLE, HOLD and ERR
- i_skip_load  in  1  sampled with i_start; in HOLD, replay the resident image without a flash read
- i_num_words  in  15  words to stream; sampled with i_start
- i_abort  in  1  return to IDLE from any state
- o_busy  out  1  high in DROP, LOAD, PRIME, STREAM, DRAIN
- o_done  out  1  one-cycle pulse when the last word is accepted downstream
- o_error  out  1  sticky load timeout
- o_init  out  1  to loader i_init
- o_fill  out  1  to loader i_fill
- i_load_done  in  1  from loader o_load_done
- i_fifo_empty  in  1  from loader o_fifo_empty
- o_fifo_rd  out  1  to loader i_fifo_rd
- i_fifo_dout  in  32  loader FIFO head word, valid while !i_fifo_empty
- o_data  out  32  stream data
- o_valid  out  1  stream valid
- i_ready  in  1  stream ready
- o_words_left  out  15  remaining words not yet popped

Behaviour:
- Reset: state IDLE. All outputs 0: o_init, o_fill, o_fifo_rd, o_valid, o_done, o_error, o_busy, o_data, o_words_left.
- Word count latch: n = min(i_num_words, MAX_WORDS) on accepted i_start. o_words_left is loaded with n.
- States and transitions:
  - IDLE: o_init=0, o_fill=0.
    - i_start -> DROP (i_skip_load ignored).
  - DROP: o_init=0, count DROP_CYCLES, then -> LOAD.
  - LOAD: o_init=1, timeout counter runs.
    - i_load_done -> PRIME.
    - Counter reaches LOAD_TIMEOUT-1 without i_load_done -> ERR.
  - PRIME: o_init=1, o_fill=1.
    - !i_fifo_empty -> STREAM.
    - If n==0, -> HOLD directly, no fill.
  - STREAM: o_init=1, o_fill=1.
    - o_fifo_rd = !i_fifo_empty && (o_words_left!=0) && (!o_valid || i_ready).
    - On o_fifo_rd: o_data<=i_fifo_dout, o_valid<=1, o_words_left decrements.
    - If i_ready && o_valid and no pop in that cycle: o_valid<=0.
    - o_words_left==0 -> DRAIN.
  - DRAIN: o_init=1, o_fill=1.
    - o_valid && i_ready -> HOLD with o_done=1 for that cycle.
    - If o_valid is already 0 -> HOLD immediately.
  - HOLD: o_init=1 (image resident), o_fill=0 (resets the loader read pointer).
    - i_start && i_skip_load -> PRIME.
    - i_start && !i_skip_load -> DROP.
  - ERR: o_init=0, o_fill=0, o_error=1.
    - i_start -> DROP; o_error clears on entry to DROP.
- Loader FIFO timing: the head word is valid combinationally while !i_fifo_empty. After o_fifo_rd the next word is visible one cycle later, so back-to-back pops every cycle are legal. Throughput is 1 word/cycle with i_ready held high.
- Stream rules:
  - o_data is stable while o_valid && !i_ready.
  - At most one pop per cycle.
  - Never pop when o_words_left==0.
  - Words are delivered in FIFO order.
- Entering PRIME via skip_load always passes through ≥1 HOLD cycle with o_fill=0.
- i_abort, in any state and with priority over all other events:
  - -> IDLE next cycle.
  - o_init, o_fill, o_valid, o_fifo_rd go to 0.
  - o_done is not pulsed.
  - o_error is cleared.
- i_start outside IDLE/HOLD/ERR is ignored.
- Timeout and word counters are unsigned with no wrap; the timeout counter saturates.

Decomposition:
- Shared package: state encoding (8 states, 3-bit), MAX_WORDS, default LOAD_TIMEOUT.
- One natural sub-module: spram_stream_outreg, a 1-entry valid/ready output register with pop-enable generation. Remaining FSM and counters stay in the top.

Test Plan:
- Start n=4 with i_ready=1 and a loader model holding 0x11..0x44 -> DROP 4 cycles, LOAD, PRIME. Then 4 consecutive beats 0x11,0x22,0x33,0x44, o_done pulse, state HOLD, o_init=1, o_fill=0.
- n=8 with i_ready toggling 1,0,0,1… -> o_data stable across stalls, no lost or duplicated words, exactly 8 pops, o_words_left reaches 0.
- From HOLD, start with i_skip_load=1, n=2 -> no o_init drop. o_fill low ≥1 cycle then high; words 0x11,0x22 replayed; o_done.
- LOAD_TIMEOUT=100, i_load_done never asserted -> ERR at cycle 100 of LOAD, o_error=1, o_init=0. Next i_start clears o_error.
- n=0 -> load completes, PRIME then HOLD, no o_fifo_rd, no o_valid, o_done not pulsed.
- i_abort after 2 of 6 words -> IDLE next cycle, o_valid=0, o_init=0, no o_done. A fresh start reloads and streams from word 0.
